// File: rtl/arbitro_rr.sv
// arbitro_rr: registered round-robin arbiter over N requesters; the grant is held while its owner keeps requesting.
// Optional macro ARB_TIMEOUT_EN forces rotation after MAX_HOLD cycles when others are waiting.
module arbitro_rr #(
  parameter int N = 4,
  parameter int NUM_W = (N > 1) ? $clog2(N) : 1,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     R,
  output logic [N-1:0]     Grant,
  output logic [NUM_W-1:0] Grant_num,
  output logic             Av,
  output logic             Expired
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [NUM_W-1:0] ptr, ptr_nx, win, num_nx;
  logic [N-1:0] cand, rot, grant_nx;
  logic [2*N-1:0] dbl;
  logic owner_req, tmo, take;
  int off, sum;

  if (N < 1 || MAX_HOLD < 1) begin : g_bad_param
    $error("arbitro_rr: N and MAX_HOLD must be >= 1");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_cnt <= '0;
      Expired <= 1'b0;
    end else begin
      Expired <= tmo;
      hold_cnt <= take ? '0 : (owner_req && hold_cnt != HOLD_LAST) ? hold_cnt + 1'b1 : hold_cnt;
    end
`else
  assign Expired = 1'b0;
`endif

  // The owner is masked out of the search, so a timeout re-arbitration never re-picks it.
  always_comb begin
    cand = R & ~Grant;
    dbl = {cand, cand} >> ptr;
    rot = dbl[N-1:0];
    off = 0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? k : off;
    sum = int'(ptr) + off;
    win = NUM_W'(sum >= N ? sum - N : sum);
    owner_req = |(R & Grant);
`ifdef ARB_TIMEOUT_EN
    tmo = owner_req && hold_cnt == HOLD_LAST && |cand;
`else
    tmo = 1'b0;
`endif
    take = (state == IDLE || !owner_req || tmo) && |cand;
    grant_nx = take ? N'(1) << win : (owner_req ? Grant : '0);
    num_nx = take ? win : (owner_req ? Grant_num : '0);
    ptr_nx = take ? NUM_W'((int'(win) + 1) % N) : ptr;
    state_nx = (take || owner_req) ? BUSY : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      Grant <= '0;
      Grant_num <= '0;
      Av <= 1'b1;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      Grant <= grant_nx;
      Grant_num <= num_nx;
      Av <= ~|grant_nx;
    end
endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr: scoreboard bench for arbitro_rr (N=4, MAX_HOLD=4); expectations come from a behavioural model.
module tb_arbitro_rr;
  localparam int MAXH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] R = '0;
  logic [3:0] Grant;
  logic [1:0] Grant_num;
  logic Av, Expired;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e, got;
  int m_owner, m_ptr, m_cnt;
  bit m_busy;

  arbitro_rr #(.N(4), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst_n(rst_n), .R(R), .Grant(Grant),
    .Grant_num(Grant_num), .Av(Av), .Expired(Expired)
  );

  always #5 clk = ~clk;

  assign got = {Grant, Grant_num, Av, Expired};

  task automatic model_reset();
    m_owner = 0; m_ptr = 0; m_cnt = 0; m_busy = 0;
  endtask

  // Predicts the registered outputs after the next edge for request vector r.
  task automatic model_push(input logic [3:0] r);
    int w;
    bit tmo;
    logic [3:0] g;
    w = -1;
    tmo = 0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (w < 0 && r[j] && !(m_busy && j == m_owner)) w = j;
    end
`ifdef ARB_TIMEOUT_EN
    if (m_busy && r[m_owner] && m_cnt == MAXH - 1 && w >= 0) tmo = 1;
`endif
    if (m_busy && r[m_owner] && !tmo) begin
      if (m_cnt < MAXH - 1) m_cnt++;
    end else if (w >= 0) begin
      m_owner = w; m_busy = 1; m_ptr = (w + 1) % 4; m_cnt = 0;
    end else m_busy = 0;
    g = m_busy ? 4'(1 << m_owner) : 4'b0000;
    exp_q.push_back({g, m_busy ? 2'(m_owner) : 2'd0, !m_busy, tmo});
  endtask

  task automatic drive(input logic [3:0] r);
    R = r;
    model_push(r);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    R = '0;
    model_reset();
    #12;
    n_tests++;
    if (got !== 8'b0000_00_1_0) begin
      n_fail++;
      $display("FAIL reset: got {Grant,Grant_num,Av,Expired}=%b, required %b", got, 8'b0000_00_1_0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    repeat (5) begin
      drive(4'b0000);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_tests++;
      if (got !== e || Av !== 1'b1) begin
        n_fail++;
        $display("FAIL idle: got %b, required %b", got, e);
      end
    end
  endtask

  task automatic test_grant_hold();
    for (int c = 0; c < 11; c++) begin
      drive(4'b1010);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL hold c%0d: got %b, required %b", c, got, e);
      end
      if (c == 0) begin
        n_tests++;
        if (Grant !== 4'b0010 || Grant_num !== 2'd1 || Av !== 1'b0) begin
          n_fail++;
          $display("FAIL first_grant: Grant=%b num=%0d Av=%b, required 0010 1 0", Grant, Grant_num, Av);
        end
      end
    end
  endtask

  task automatic test_handoff();
    drive(4'b1000);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_tests++;
    if (got !== e || Grant !== 4'b1000 || Grant_num !== 2'd3 || Av !== 1'b0) begin
      n_fail++;
      $display("FAIL handoff: got %b, required %b (Grant 1000, num 3, Av 0)", got, e);
    end
  endtask

  task automatic test_back_to_back();
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] r;
    drive(4'b0000);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL b2b_idle: got %b, required %b", got, e);
    end
    r = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      drive(r);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_tests++;
      if (got !== e || Grant !== 4'(1 << seq[i]) || int'(Grant_num) != seq[i]) begin
        n_fail++;
        $display("FAIL b2b%0d: got %b, required %b (owner %0d)", i, got, e, seq[i]);
      end
      r = 4'b1111 & ~4'(1 << seq[i]);
    end
  endtask

  task automatic test_release();
    drive(4'b0100);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_tests++;
    if (got !== e || Grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL release_handoff: got %b, required %b", got, e);
    end
    drive(4'b0000);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_tests++;
    if (got !== e || got !== 8'b0000_00_1_0) begin
      n_fail++;
      $display("FAIL release_idle: got %b, required %b", got, e);
    end
  endtask

  task automatic test_async_reset();
    drive(4'b0001);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_tests++;
    if (got !== e || Grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL pre_reset_grant: got %b, required %b", got, e);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (Grant !== 4'b0000 || Av !== 1'b1 || Grant_num !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: Grant=%b Av=%b num=%0d, required 0000 1 0", Grant, Av, Grant_num);
    end
    model_reset();
    R = 4'b0000;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
    logic [3:0] eg[10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                           4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
    logic ex[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    logic [3:0] eg[10] = '{default: 4'b0001};
    logic ex[10] = '{default: 1'b0};
`endif
    for (int c = 0; c < 10; c++) begin
      drive(4'b0011);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_tests++;
      if (got !== e || Grant !== eg[c] || Expired !== ex[c]) begin
        n_fail++;
        $display("FAIL timeout c%0d: got %b, required %b (Grant %b Expired %b)", c, got, e, eg[c], ex[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_grant_hold();
    test_handoff();
    test_back_to_back();
    test_release();
    test_async_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arbitro_rr.md
Name: arbitro_rr

Overview:
- Parametrised, registered successor to the team's 4-input fixed-priority arbiter.
- N requesters; round-robin priority; the grant is held while the owner keeps requesting.
- Back-to-back handoff with no idle bubble.
- Outputs keep the existing one-hot Grant / binary Grant_num / Av contract, now registered and always defined. Sits in front of shared resources (bus, memory port) used by multiple masters.

Parameters:
- N, 4, number of requesters (N >= 1).
- NUM_W, (N>1 ? $clog2(N) : 1), width of Grant_num; derived, not overridden.
- MAX_HOLD, 16, maximum consecutive grant cycles before forced rotation (used only with ARB_TIMEOUT_EN; MAX_HOLD >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- R  input  N  request vector; R[i]=1 means requester i wants or keeps the resource.
- Grant  output  N  registered one-hot grant; all zero when nothing is granted.
- Grant_num  output  NUM_W  binary index of the granted requester; 0 when Av=1.
- Av  output  1  registered; 1 when no grant is active (Av == ~|Grant).
- Expired  output  1  one-cycle pulse when a grant is revoked by timeout; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release): Grant=0, Grant_num=0, Av=1, Expired=0, ptr=0, state=IDLE, hold_cnt=0.
- ptr is the highest-priority index. Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1. The first requester with R=1 wins.
- States: IDLE and BUSY.
- IDLE:
  - R==0: stay in IDLE; outputs unchanged.
  - R!=0: winner w is registered on the next edge. Grant = 1<<w, Grant_num = w, Av=0, ptr <= (w+1) mod N, go to BUSY.
  - Latency is 1 cycle from request to Grant.
- BUSY, owner o:
  - R[o]=1: hold Grant and Grant_num unchanged; ptr unchanged.
  - R[o]=0 and another request is pending: the new winner is granted on the same edge the owner releases (no bubble). ptr is updated; stay in BUSY.
  - R[o]=0 and no other request: Grant=0, Grant_num=0, Av=1, go to IDLE.
- Requests from non-owners never affect Grant while the owner holds.
- Requests that change mid-cycle are sampled only at the clock edge; no combinational path from R to any output.
- Wrap-around: with o=N-1 the next ptr is 0.
- N=1: Grant[0] follows R[0] delayed by 1 cycle; Grant_num is always 0.
- Reset asserted mid-grant: outputs clear immediately (asynchronous). Arbitration restarts from ptr=0.
- Invariants:
  - Grant is always one-hot or zero.
  - Grant_num always matches Grant.
  - A granted requester never has R=0 for more than the one cycle needed to register the release.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt (width $clog2(MAX_HOLD+1)) counts cycles the current owner has held the grant. It is cleared on every new grant.
  - When hold_cnt == MAX_HOLD-1, R[o]=1, and any other R[j]=1 (j != o): on the next edge, re-arbitrate as if the owner released.
  - Search starts from ptr, which is already o+1, so the owner has lowest priority. Expired pulses 1 for that cycle; a new owner is granted with no bubble.
  - If no other request is pending, the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
- Undefined: no counter is instantiated, Expired is tied 0, and a grant is held indefinitely while R[o]=1.

Test Plan:
- N=4, reset, then R=0000 for 5 cycles -> Grant=0000, Grant_num=0, Av=1 on every cycle.
- From reset, R=1010 -> one cycle later Grant=0010, Grant_num=1, Av=0. Hold R=1010 for 10 cycles -> Grant stays 0010 throughout.
- Owner releases: R goes 1010->1000 -> next edge Grant=1000, Grant_num=3, with no Av=1 cycle in between.
- Continuous R=1111 with each owner dropping its request for exactly one cycle after being granted -> grant sequence 0,1,2,3,0,1 (wrap-around checked).
- Last owner releases: R 0100->0000 -> next edge Grant=0000, Av=1, Grant_num=0. Assert rst_n=0 mid-grant -> Grant=0 immediately, without waiting for a clock edge.
- ARB_TIMEOUT_EN defined, MAX_HOLD=4, R=0011 held constant:
  - Grant=0001 for 4 cycles, then Grant=0010 with Expired=1 for one cycle.
  - After 4 more cycles, Grant returns to 0001.
  - Without the macro, Grant stays 0001 for the whole run.
